// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Two-master arbiter that lets an instruction-fetch port and a
//            data (MEM) port share one Wishbone-style bus. Data accesses
//            normally win. When both ports are eligible and the previous grant
//            went to MEM, the fetch port wins instead, so neither port starves.
//            Each grant issues one registered bus command and waits for
//            bus_ack_i. The response is then returned to the owner as a
//            one-cycle ack pulse.
// Revision : 1.0 - initial release
//
// Ports
//   clk, rst            : clock; synchronous active-high reset
//   if_req_i/if_addr_i  : fetch request and byte address (held until ack)
//   if_data_o/if_ack_o  : fetched word and its completion pulse
//   mem_req_i/mem_we_i/mem_sel_i/mem_addr_i/mem_wdata_i : data request
//   mem_rdata_o/mem_ack_o                               : data response
//   bus_cyc_o/bus_stb_o/bus_we_o/bus_sel_o/bus_addr_o/bus_wdata_o : bus cmd
//   bus_rdata_i/bus_ack_i : bus response
//   stallreq_o          : pipeline stall request (combinational)
//   timeout_o           : one-cycle pulse when a bus cycle is aborted
//
// Build option
//   ARB_TIMEOUT_EN : when defined, a bus cycle with no bus_ack_i for
//                    TIMEOUT_CYCLES cycles is aborted. The owner receives
//                    data 0 and timeout_o pulses.
// ============================================================================
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stallreq_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last_grant, w_last_grant_nxt;   // 0 = IF, 1 = MEM
  logic        r_cyc, w_cyc_nxt;
  logic        r_we, w_we_nxt;
  logic [3:0]  r_sel, w_sel_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic        r_if_ack, w_if_ack_nxt;
  logic        r_mem_ack, w_mem_ack_nxt;
  logic [31:0] r_if_data, w_if_data_nxt;
  logic [31:0] r_mem_data, w_mem_data_nxt;

  // Completion of the current bus cycle and the word handed to its owner
  logic        w_done;
  logic [31:0] w_done_data;

  // A port whose ack is being presented this cycle is still holding its old
  // request. It must not be re-granted until the requester has seen the ack.
  logic w_if_elig, w_mem_elig, w_grant_mem, w_grant_if;
  assign w_if_elig   = if_req_i  & ~r_if_ack;
  assign w_mem_elig  = mem_req_i & ~r_mem_ack;
  assign w_grant_mem = w_mem_elig & (~w_if_elig | ~r_last_grant);
  assign w_grant_if  = w_if_elig & ~w_grant_mem;

`ifdef ARB_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic               r_timeout, w_timeout_nxt;
`else
  // TIMEOUT_CYCLES has no effect when the abort logic is not built
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_cyc_nxt        = r_cyc;
    w_we_nxt         = r_we;
    w_sel_nxt        = r_sel;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_if_ack_nxt     = 1'b0;
    w_mem_ack_nxt    = 1'b0;
    w_if_data_nxt    = r_if_data;
    w_mem_data_nxt   = r_mem_data;
    w_done           = 1'b0;
    w_done_data      = 32'h0000_0000;
`ifdef ARB_TIMEOUT_EN
    w_cnt_nxt        = r_cnt;
    w_timeout_nxt    = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        // bus_ack_i is deliberately not looked at here
        if (w_grant_mem) begin
          w_state_nxt      = ST_BUSY_MEM;
          w_last_grant_nxt = 1'b1;
          w_cyc_nxt        = 1'b1;
          w_we_nxt         = mem_we_i;
          w_sel_nxt        = mem_sel_i;
          w_addr_nxt       = mem_addr_i;
          w_wdata_nxt      = mem_wdata_i;
`ifdef ARB_TIMEOUT_EN
          w_cnt_nxt        = '0;
`endif
        end else if (w_grant_if) begin
          w_state_nxt      = ST_BUSY_IF;
          w_last_grant_nxt = 1'b0;
          w_cyc_nxt        = 1'b1;
          w_we_nxt         = 1'b0;
          w_sel_nxt        = 4'b1111;
          w_addr_nxt       = if_addr_i;
          w_wdata_nxt      = 32'h0000_0000;
`ifdef ARB_TIMEOUT_EN
          w_cnt_nxt        = '0;
`endif
        end
      end

      ST_BUSY_IF, ST_BUSY_MEM: begin
        if (bus_ack_i) begin
          w_done      = 1'b1;
          w_done_data = bus_rdata_i;
        end
`ifdef ARB_TIMEOUT_EN
        // r_cnt counts the ack-less cycles already spent. The abort happens
        // at the end of the TIMEOUT_CYCLES-th such cycle.
        else if (r_cnt == c_cnt_last) begin
          w_done        = 1'b1;
          w_done_data   = 32'h0000_0000;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
`endif
        if (w_done) begin
          w_state_nxt = ST_IDLE;
          w_cyc_nxt   = 1'b0;
          if (r_state == ST_BUSY_IF) begin
            w_if_ack_nxt  = 1'b1;
            w_if_data_nxt = w_done_data;
          end else begin
            w_mem_ack_nxt  = 1'b1;
            w_mem_data_nxt = w_done_data;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cyc_nxt   = 1'b0;
      end
    endcase
  end

  // Reset wins over everything, including an ack arriving in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b0;
      r_cyc        <= 1'b0;
      r_we         <= 1'b0;
      r_sel        <= 4'b0000;
      r_addr       <= 32'h0000_0000;
      r_wdata      <= 32'h0000_0000;
      r_if_ack     <= 1'b0;
      r_mem_ack    <= 1'b0;
      r_if_data    <= 32'h0000_0000;
      r_mem_data   <= 32'h0000_0000;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cyc        <= w_cyc_nxt;
      r_we         <= w_we_nxt;
      r_sel        <= w_sel_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_if_ack     <= w_if_ack_nxt;
      r_mem_ack    <= w_mem_ack_nxt;
      r_if_data    <= w_if_data_nxt;
      r_mem_data   <= w_mem_data_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end
  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  assign bus_cyc_o   = r_cyc;
  assign bus_stb_o   = r_cyc;
  assign bus_we_o    = r_we;
  assign bus_sel_o   = r_sel;
  assign bus_addr_o  = r_addr;
  assign bus_wdata_o = r_wdata;
  assign if_ack_o    = r_if_ack;
  assign if_data_o   = r_if_data;
  assign mem_ack_o   = r_mem_ack;
  assign mem_rdata_o = r_mem_data;

  assign stallreq_o = (if_req_i & ~r_if_ack) | (mem_req_i & ~r_mem_ack);

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter. It applies a table of
//            directed vectors, a few multi-cycle sequences and then
//            randomized traffic. All of it is compared against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, bus_ack = 1'b0;
  logic [3:0]  mem_sel = 4'h0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, bus_rdata = '0;
  logic [31:0] if_data_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic        if_ack_o, mem_ack_o, bus_cyc_o, bus_stb_o, bus_we_o;
  logic        stallreq_o, timeout_o;
  logic [3:0]  bus_sel_o;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata),
    .bus_ack_i(bus_ack), .stallreq_o(stallreq_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model: one bus transaction at a time ----------
  int          m_owner = 0;        // 0 none, 1 fetch port, 2 data port
  bit          m_prefer_if = 0;    // previous winner was the data port
  logic        m_we = 0;
  logic [3:0]  m_sel = 0;
  logic [31:0] m_addr = 0, m_wd = 0, m_idata = 0, m_mdata = 0;
  bit          m_iack = 0, m_mack = 0, m_to = 0;
  int          m_wait = 0;

  task automatic model_step();
    bit if_ok, mem_ok, done;
    int win;
    logic [31:0] d;
    if (rst) begin
      m_owner = 0; m_prefer_if = 0; m_we = 0; m_sel = 0; m_addr = 0; m_wd = 0;
      m_idata = 0; m_mdata = 0; m_iack = 0; m_mack = 0; m_to = 0; m_wait = 0;
      return;
    end
    if_ok  = if_req && !m_iack;
    mem_ok = mem_req && !m_mack;
    m_iack = 0; m_mack = 0; m_to = 0;
    if (m_owner == 0) begin
      win = 0;
      if (if_ok && mem_ok) win = m_prefer_if ? 1 : 2;
      else if (mem_ok)     win = 2;
      else if (if_ok)      win = 1;
      if (win == 1) begin
        m_we = 0; m_sel = 4'hF; m_addr = if_addr; m_wd = 0;
      end else if (win == 2) begin
        m_we = mem_we; m_sel = mem_sel; m_addr = mem_addr; m_wd = mem_wdata;
      end
      if (win != 0) begin
        m_owner = win; m_prefer_if = (win == 2); m_wait = 0;
      end
    end else begin
      done = 0; d = 0;
      if (bus_ack) begin
        done = 1; d = bus_rdata;
      end else begin
        m_wait++;
`ifdef ARB_TIMEOUT_EN
        if (m_wait == TMO) begin done = 1; d = 0; m_to = 1; end
`endif
      end
      if (done) begin
        if (m_owner == 1) begin m_iack = 1; m_idata = d; end
        else begin m_mack = 1; m_mdata = d; end
        m_owner = 0;
      end
    end
  endtask

  // One clock: advance the model at the edge, compare 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("cyc", bus_cyc_o, m_owner != 0);
    chk("stb", bus_stb_o, m_owner != 0);
    chk("if_ack", if_ack_o, m_iack);
    chk("mem_ack", mem_ack_o, m_mack);
    chk("if_data", if_data_o, m_idata);
    chk("mem_rdata", mem_rdata_o, m_mdata);
    chk("timeout", timeout_o, m_to);
    chk("stallreq", stallreq_o, (if_req & ~m_iack) | (mem_req & ~m_mack));
    if (m_owner != 0) begin
      chk("bus_we", bus_we_o, m_we);
      chk("bus_sel", bus_sel_o, m_sel);
      chk("bus_addr", bus_addr_o, m_addr);
      chk("bus_wdata", bus_wdata_o, m_wd);
    end
  endtask

  task automatic do_reset();
    if_req = 0; mem_req = 0; mem_we = 0; mem_sel = 0; bus_ack = 0;
    rst = 1; tick(); rst = 0;
  endtask

  // ---------------- directed vector table -----------------------------------
  typedef struct {
    logic rst; logic ireq; logic [31:0] iaddr;
    logic mreq; logic mwe; logic [3:0] msel; logic [31:0] maddr; logic [31:0] mwd;
    logic back; logic [31:0] brd;
    logic e_cyc; logic e_we; logic [3:0] e_sel; logic [31:0] e_addr; logic [31:0] e_wd;
    logic e_iack; logic e_mack; logic [31:0] e_idata; logic [31:0] e_mdata; logic e_stall;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl[NV];

  initial begin
    int n;
    int order[4];
    int busy;

    // single fetch, turnaround block, then collision after reset
    tbl[0]  = '{1,0,0,           0,0,0,0,0,                       0,0,            0,0,0,0,0,                       0,0,0,0,                     0};
    tbl[1]  = '{0,1,32'h4,       0,0,0,0,0,                       0,0,            1,0,4'hF,32'h4,0,                0,0,0,0,                     1};
    tbl[2]  = '{0,1,32'h4,       0,0,0,0,0,                       1,32'h34011100, 0,0,0,0,0,                       1,0,32'h34011100,0,          0};
    tbl[3]  = '{0,1,32'h4,       0,0,0,0,0,                       0,0,            0,0,0,0,0,                       0,0,32'h34011100,0,          1};
    tbl[4]  = '{0,0,0,           0,0,0,0,0,                       0,0,            0,0,0,0,0,                       0,0,32'h34011100,0,          0};
    tbl[5]  = '{1,0,0,           0,0,0,0,0,                       0,0,            0,0,0,0,0,                       0,0,0,0,                     0};
    tbl[6]  = '{0,1,32'h100,     1,1,4'h3,32'hA0,32'hDEADBEEF,    0,0,            1,1,4'h3,32'hA0,32'hDEADBEEF,    0,0,0,0,                     1};
    tbl[7]  = '{0,1,32'h100,     1,1,4'h3,32'hA0,32'hDEADBEEF,    1,32'h11111111, 0,0,0,0,0,                       0,1,0,32'h11111111,          1};
    tbl[8]  = '{0,1,32'h100,     1,1,4'h3,32'hA0,32'hDEADBEEF,    1,32'h22222222, 1,0,4'hF,32'h100,0,              0,0,0,32'h11111111,          1};
    tbl[9]  = '{0,1,32'h100,     0,0,0,0,0,                       0,0,            1,0,4'hF,32'h100,0,              0,0,0,32'h11111111,          1};
    tbl[10] = '{0,1,32'h100,     0,0,0,0,0,                       1,32'h33333333, 0,0,0,0,0,                       1,0,32'h33333333,32'h11111111, 0};
    tbl[11] = '{0,0,0,           0,0,0,0,0,                       0,0,            0,0,0,0,0,                       0,0,32'h33333333,32'h11111111, 0};

    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst; if_req = tbl[i].ireq; if_addr = tbl[i].iaddr;
      mem_req = tbl[i].mreq; mem_we = tbl[i].mwe; mem_sel = tbl[i].msel;
      mem_addr = tbl[i].maddr; mem_wdata = tbl[i].mwd;
      bus_ack = tbl[i].back; bus_rdata = tbl[i].brd;
      tick();
      chk($sformatf("v%0d_cyc", i), bus_cyc_o, tbl[i].e_cyc);
      chk($sformatf("v%0d_if_ack", i), if_ack_o, tbl[i].e_iack);
      chk($sformatf("v%0d_mem_ack", i), mem_ack_o, tbl[i].e_mack);
      chk($sformatf("v%0d_if_data", i), if_data_o, tbl[i].e_idata);
      chk($sformatf("v%0d_mem_rdata", i), mem_rdata_o, tbl[i].e_mdata);
      chk($sformatf("v%0d_stall", i), stallreq_o, tbl[i].e_stall);
      if (tbl[i].e_cyc) begin
        chk($sformatf("v%0d_we", i), bus_we_o, tbl[i].e_we);
        chk($sformatf("v%0d_sel", i), bus_sel_o, tbl[i].e_sel);
        chk($sformatf("v%0d_addr", i), bus_addr_o, tbl[i].e_addr);
        chk($sformatf("v%0d_wdata", i), bus_wdata_o, tbl[i].e_wd);
      end
    end
    rst = 0;

    // alternation: both ports request continuously, bus acks immediately
    do_reset();
    if_req = 1; if_addr = 32'h200;
    mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h300;
    bus_ack = 1; bus_rdata = 32'h0BAD_F00D;
    n = 0;
    for (int k = 0; k < 4; k++) order[k] = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (mem_ack_o && n < 4) begin order[n] = 2; n++; end
      if (if_ack_o && n < 4) begin order[n] = 1; n++; end
    end
    chk("alt_count", n, 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("alt_order%0d", k), order[k], (k % 2 == 0) ? 2 : 1);
    if_req = 0; mem_req = 0; bus_ack = 0;
    tick();

    // reset in the second busy cycle while the bus acks
    do_reset();
    mem_req = 1; mem_we = 1; mem_sel = 4'h5; mem_addr = 32'h40; mem_wdata = 32'hCAFE0001;
    bus_ack = 0;
    tick();
    tick();
    rst = 1; bus_ack = 1; bus_rdata = 32'h99;
    tick();
    chk("rst_mid_ack", mem_ack_o, 0);
    chk("rst_mid_cyc", bus_cyc_o, 0);
    chk("rst_mid_stall", stallreq_o, 1);
    mem_req = 0; #1;
    chk("rst_mid_stall_drop", stallreq_o, 0);
    rst = 0; bus_ack = 0;
    tick();

    // stall held for five request cycles, released in the ack cycle
    do_reset();
    mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h80; bus_rdata = 32'h5A5A0F0F;
    for (int i = 0; i < 5; i++) begin
      bus_ack = (i == 4);
      #1;
      chk($sformatf("stall_hold%0d", i), stallreq_o, 1);
      tick();
    end
    chk("stall_ack", mem_ack_o, 1);
    chk("stall_release", stallreq_o, 0);
    chk("stall_data", mem_rdata_o, 32'h5A5A0F0F);
    mem_req = 0; bus_ack = 0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // bus never answers: abort after TMO busy cycles
    do_reset();
    mem_req = 1; mem_we = 0; mem_addr = 32'hC0; bus_ack = 0;
    busy = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (mem_ack_o) break;
      if (bus_cyc_o) busy++;
    end
    chk("tmo_busy_cycles", busy, TMO);
    chk("tmo_ack", mem_ack_o, 1);
    chk("tmo_pulse", timeout_o, 1);
    chk("tmo_data", mem_rdata_o, 0);
    chk("tmo_cyc", bus_cyc_o, 0);
    mem_req = 0;
    tick();
`endif

    // randomized traffic; requesters only change after their ack
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!if_req || m_iack) begin
        if_req  = $urandom_range(0, 1);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!mem_req || m_mack) begin
        mem_req   = $urandom_range(0, 1);
        mem_we    = $urandom_range(0, 1);
        mem_sel   = 4'($urandom);
        mem_addr  = $urandom;
        mem_wdata = $urandom;
      end
      bus_ack   = ($urandom_range(0, 2) == 0);
      bus_rdata = $urandom;
      tick();
    end
    rst = 0; if_req = 0; mem_req = 0; bus_ack = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
